// File: rtl/sms_timing_ring.sv
// sms_timing_ring
//   One-hot timing-phase ring sequencer. A divided system clock advances a
//   ring of PHASES phases. The ring starts on a START 0->1 edge and can run
//   continuously, run one full ring cycle, or take a single phase step.
//   In continuous mode, STOP halts the ring at the next wrap.
//
// Parameters
//   DIV     SYSCLOCK cycles per phase step (1..256)
//   PHASES  number of timing phases in the ring (2..32)
//
// Ports
//   SYSCLOCK   in   system clock, rising-edge active
//   RESET_N    in   asynchronous active-low reset
//   START      in   start request, acted on at its 0->1 edge while idle
//   STOP       in   level request to halt at the end of the current ring cycle
//   MODE       in   00 run, 01 single-cycle, 10 single-step, 11 run
//   T          out  one-hot timing phases
//   PHASE_IDX  out  binary index of the set bit of T
//   TICK       out  one-cycle strobe on every phase advance
//   CYCLE_END  out  one-cycle strobe on the PHASES-1 -> 0 advance
//   RUNNING    out  high while the ring is running or halting
module sms_timing_ring #(
    parameter int unsigned DIV    = 2,
    parameter int unsigned PHASES = 10
) (
    input  logic                      SYSCLOCK,
    input  logic                      RESET_N,
    input  logic                      START,
    input  logic                      STOP,
    input  logic [1:0]                MODE,
    output logic [PHASES-1:0]         T,
    output logic [$clog2(PHASES)-1:0] PHASE_IDX,
    output logic                      TICK,
    output logic                      CYCLE_END,
    output logic                      RUNNING
);

    localparam int unsigned IW = $clog2(PHASES);
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0]     DIV_LAST = DW'(DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(PHASES - 1);
    localparam logic [PHASES-1:0] T_INIT   = PHASES'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_HALT_PEND = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        M_RUN     = 2'b00,
        M_CYCLE   = 2'b01,
        M_STEP    = 2'b10,
        M_RUN_ALT = 2'b11
    } mode_t;

    state_t          state;
    state_t          state_next;
    mode_t           mode_q;
    logic [DW-1:0]   div_cnt;
    // Set only once START has been sampled low after reset, so a START held
    // high through reset release never looks like a rising edge.
    logic            start_low;

    logic            start_edge;
    logic            tick;
    logic            wrap;
    logic            load;

    // State register
    always_ff @(posedge SYSCLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath controls
    always_comb begin
        start_edge = START & start_low;
        tick       = (state != S_IDLE) && (div_cnt == DIV_LAST);
        wrap       = tick && (PHASE_IDX == IDX_LAST);
        state_next = state;
        load       = 1'b0;

        case (state)
            S_IDLE: begin
                // STOP wins over a coincident START edge.
                if (start_edge && !STOP) begin
                    state_next = S_RUN;
                    load       = 1'b1;
                end
            end
            S_RUN: begin
                case (mode_q)
                    M_CYCLE: if (wrap) state_next = S_IDLE;
                    M_STEP:  if (tick) state_next = S_IDLE;
                    default: if (STOP) state_next = S_HALT_PEND;
                endcase
            end
            S_HALT_PEND: begin
                // Committed halt: the ring always finishes its cycle.
                if (wrap) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Divider, phase ring and registered strobes
    always_ff @(posedge SYSCLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            start_low <= 1'b0;
            mode_q    <= M_RUN;
            div_cnt   <= '0;
            T         <= T_INIT;
            PHASE_IDX <= '0;
            TICK      <= 1'b0;
            CYCLE_END <= 1'b0;
            RUNNING   <= 1'b0;
        end else begin
            start_low <= ~START;

            if (load) begin
                mode_q  <= mode_t'(MODE);
                div_cnt <= '0;
            end else if (state != S_IDLE) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
            end

            if (tick) begin
                T         <= {T[PHASES-2:0], T[PHASES-1]};
                PHASE_IDX <= wrap ? '0 : PHASE_IDX + 1'b1;
            end

            TICK      <= tick;
            CYCLE_END <= wrap;
            RUNNING   <= (state_next != S_IDLE);
        end
    end

endmodule

// File: tb/tb_sms_timing_ring.sv
// tb_sms_timing_ring
//   Scoreboard bench for sms_timing_ring. Three instances cover the main
//   configuration (DIV=2, PHASES=4), the fastest ring (DIV=1, PHASES=2) and
//   the widest ring (DIV=1, PHASES=32). Stimulus pushes the expected phase
//   index / CYCLE_END of every tick into a per-instance queue; a monitor per
//   instance pops and compares on each TICK.
module tb_sms_timing_ring;

    typedef struct packed {
        logic [7:0] idx;
        logic       ce;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       m_start, m_stop;
    logic [1:0] m_mode;
    logic [3:0] m_t;
    logic [1:0] m_idx;
    logic       m_tick, m_ce, m_run;

    logic       f_start, f_stop;
    logic [1:0] f_mode;
    logic [1:0] f_t;
    logic [0:0] f_idx;
    logic       f_tick, f_ce, f_run;

    logic        w_start, w_stop;
    logic [1:0]  w_mode;
    logic [31:0] w_t;
    logic [4:0]  w_idx;
    logic        w_tick, w_ce, w_run;

    exp_t q_main[$];
    exp_t q_fast[$];
    exp_t q_wide[$];

    int checks = 0;
    int errors = 0;

    sms_timing_ring #(.DIV(2), .PHASES(4)) u_main (
        .SYSCLOCK(clk), .RESET_N(rst_n), .START(m_start), .STOP(m_stop),
        .MODE(m_mode), .T(m_t), .PHASE_IDX(m_idx), .TICK(m_tick),
        .CYCLE_END(m_ce), .RUNNING(m_run)
    );

    sms_timing_ring #(.DIV(1), .PHASES(2)) u_fast (
        .SYSCLOCK(clk), .RESET_N(rst_n), .START(f_start), .STOP(f_stop),
        .MODE(f_mode), .T(f_t), .PHASE_IDX(f_idx), .TICK(f_tick),
        .CYCLE_END(f_ce), .RUNNING(f_run)
    );

    sms_timing_ring #(.DIV(1), .PHASES(32)) u_wide (
        .SYSCLOCK(clk), .RESET_N(rst_n), .START(w_start), .STOP(w_stop),
        .MODE(w_mode), .T(w_t), .PHASE_IDX(w_idx), .TICK(w_tick),
        .CYCLE_END(w_ce), .RUNNING(w_run)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {pad, T, PHASE_IDX, CYCLE_END} packed into one word per tick
    function automatic logic [63:0] pack(input logic [31:0] t, input logic [7:0] i, input logic c);
        return {23'd0, t, i, c};
    endfunction

    function automatic logic [63:0] exp_word(input exp_t e);
        logic [31:0] one;
        one = 32'd1;
        return pack(one << e.idx, e.idx, e.ce);
    endfunction

    // Monitors
    always @(negedge clk) begin : mon_main
        exp_t e;
        if (m_tick) begin
            if (q_main.size() == 0) begin
                chk("main_unexpected_tick", 64'd1, 64'd0);
            end else begin
                e = q_main.pop_front();
                chk("main_tick", pack(32'(m_t), 8'(m_idx), m_ce), exp_word(e));
            end
        end else if (m_ce) begin
            chk("main_cycle_end_without_tick", 64'd1, 64'd0);
        end
    end

    always @(negedge clk) begin : mon_fast
        exp_t e;
        if (f_tick) begin
            if (q_fast.size() == 0) begin
                chk("fast_unexpected_tick", 64'd1, 64'd0);
            end else begin
                e = q_fast.pop_front();
                chk("fast_tick", pack(32'(f_t), 8'(f_idx), f_ce), exp_word(e));
            end
        end else if (f_ce) begin
            chk("fast_cycle_end_without_tick", 64'd1, 64'd0);
        end
    end

    always @(negedge clk) begin : mon_wide
        exp_t e;
        if (w_tick) begin
            if (q_wide.size() == 0) begin
                chk("wide_unexpected_tick", 64'd1, 64'd0);
            end else begin
                e = q_wide.pop_front();
                chk("wide_tick", pack(w_t, 8'(w_idx), w_ce), exp_word(e));
            end
        end else if (w_ce) begin
            chk("wide_cycle_end_without_tick", 64'd1, 64'd0);
        end
    end

    function automatic logic running_of(input int which);
        case (which)
            0:       return m_run;
            1:       return f_run;
            default: return w_run;
        endcase
    endfunction

    task automatic set_start(input int which, input logic v);
        case (which)
            0:       m_start = v;
            1:       f_start = v;
            default: w_start = v;
        endcase
    endtask

    task automatic pulse_start(input int which);
        @(negedge clk);
        set_start(which, 1'b1);
        @(negedge clk);
        set_start(which, 1'b0);
    endtask

    task automatic wait_idle(input int which, input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (running_of(which) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(running_of(which)), 64'd0);
    endtask

    task automatic wait_main_idx(input logic [1:0] target, input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (m_idx != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(m_idx), 64'(target));
    endtask

    task automatic wait_main_drained(input int budget, input string name);
        int n = 0;
        while (q_main.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 64'(q_main.size()), 64'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int run_seq[9]  = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
        int step_seq[5] = '{1, 2, 3, 0, 1};

        rst_n   = 1'b0;
        m_start = 1'b0; m_stop = 1'b0; m_mode = 2'b00;
        f_start = 1'b0; f_stop = 1'b0; f_mode = 2'b00;
        w_start = 1'b0; w_stop = 1'b0; w_mode = 2'b00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_T",        64'(m_t),    64'h1);
        chk("rst_idx",      64'(m_idx),  64'h0);
        chk("rst_running",  64'(m_run),  64'h0);
        chk("rst_tick",     64'(m_tick), 64'h0);
        chk("rst_cycle_end",64'(m_ce),   64'h0);
        chk("rst_fast_T",   64'(f_t),    64'h1);
        chk("rst_wide_T",   64'(w_t),    64'h1);
        rst_n = 1'b1;
        @(negedge clk);

        // Continuous run, then STOP while T=0010
        for (int i = 0; i < 9; i++)
            q_main.push_back('{idx: 8'(run_seq[i]), ce: (run_seq[i] == 0)});
        pulse_start(0);
        chk("run_running_rise", 64'(m_run), 64'h1);
        chk("run_entry_T",      64'(m_t),   64'h1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("run_tick_cadence", 64'(m_tick), 64'((i % 2) == 0));
        end
        wait_main_drained(40, "run_nine_ticks");
        chk("stop_T_at_0010", 64'(m_t), 64'h2);
        q_main.push_back('{idx: 8'd2, ce: 1'b0});
        q_main.push_back('{idx: 8'd3, ce: 1'b0});
        q_main.push_back('{idx: 8'd0, ce: 1'b1});
        m_stop = 1'b1;
        repeat (2) @(negedge clk);
        m_stop = 1'b0;   // dropping STOP must not cancel the halt
        wait_idle(0, 40, "stop_halt_done");
        repeat (4) @(negedge clk);
        chk("stop_drained",   64'(q_main.size()), 64'd0);
        chk("stop_T_held",    64'(m_t),   64'h1);
        chk("stop_idx_held",  64'(m_idx), 64'h0);
        chk("stop_tick_idle", 64'(m_tick), 64'h0);

        // Single cycle, with MODE change and START edge while running
        m_mode = 2'b01;
        q_main.push_back('{idx: 8'd1, ce: 1'b0});
        q_main.push_back('{idx: 8'd2, ce: 1'b0});
        q_main.push_back('{idx: 8'd3, ce: 1'b0});
        q_main.push_back('{idx: 8'd0, ce: 1'b1});
        pulse_start(0);
        m_mode = 2'b00;
        repeat (2) @(negedge clk);
        pulse_start(0);
        wait_idle(0, 40, "single_cycle_done");
        repeat (3) @(negedge clk);
        chk("single_cycle_drained", 64'(q_main.size()), 64'd0);
        chk("single_cycle_T",       64'(m_t), 64'h1);

        // Single step, five pulses
        m_mode = 2'b10;
        for (int k = 0; k < 5; k++) begin
            q_main.push_back('{idx: 8'(step_seq[k]), ce: (step_seq[k] == 0)});
            pulse_start(0);
            wait_idle(0, 20, "step_done");
            @(negedge clk);
            chk("step_idx",     64'(m_idx), 64'(step_seq[k]));
            chk("step_drained", 64'(q_main.size()), 64'd0);
        end

        // START edge coinciding with STOP in IDLE
        m_stop = 1'b1;
        pulse_start(0);
        chk("collide_running", 64'(m_run), 64'h0);
        repeat (3) @(negedge clk);
        chk("collide_idx", 64'(m_idx), 64'h1);
        m_stop = 1'b0;

        // Asynchronous reset mid-run, START held high through release
        m_mode = 2'b00;
        q_main.push_back('{idx: 8'd2, ce: 1'b0});
        pulse_start(0);
        wait_main_idx(2'd2, 20, "reset_reach_idx2");
        #2;
        rst_n   = 1'b0;
        m_start = 1'b1;
        #1;
        chk("async_rst_T",       64'(m_t),    64'h1);
        chk("async_rst_idx",     64'(m_idx),  64'h0);
        chk("async_rst_running", 64'(m_run),  64'h0);
        chk("async_rst_tick",    64'(m_tick), 64'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("start_held_no_edge", 64'(m_run), 64'h0);
        chk("start_held_T",       64'(m_t),   64'h1);
        m_start = 1'b0;
        @(negedge clk);
        m_mode = 2'b10;
        q_main.push_back('{idx: 8'd1, ce: 1'b0});
        pulse_start(0);
        wait_idle(0, 20, "post_reset_step_done");
        @(negedge clk);
        chk("post_reset_idx",     64'(m_idx), 64'h1);
        chk("post_reset_drained", 64'(q_main.size()), 64'd0);

        // DIV=1, PHASES=2: tick every running cycle, T toggles 01/10
        for (int i = 0; i < 4; i++) begin
            q_fast.push_back('{idx: 8'd1, ce: 1'b0});
            q_fast.push_back('{idx: 8'd0, ce: 1'b1});
        end
        f_mode = 2'b00;
        pulse_start(1);
        chk("fast_entry_tick", 64'(f_tick), 64'h0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("fast_tick_every_cycle", 64'(f_tick), 64'h1);
        end
        f_stop = 1'b1;
        wait_idle(1, 20, "fast_halt_done");
        repeat (3) @(negedge clk);
        f_stop = 1'b0;
        chk("fast_drained", 64'(q_fast.size()), 64'd0);
        chk("fast_T_held",  64'(f_t), 64'h1);

        // PHASES=32: single cycle through the wrap at index 31
        for (int i = 1; i < 32; i++)
            q_wide.push_back('{idx: 8'(i), ce: 1'b0});
        q_wide.push_back('{idx: 8'd0, ce: 1'b1});
        w_mode = 2'b01;
        pulse_start(2);
        wait_idle(2, 100, "wide_cycle_done");
        repeat (3) @(negedge clk);
        chk("wide_drained", 64'(q_wide.size()), 64'd0);
        chk("wide_idx",     64'(w_idx), 64'h0);
        chk("wide_T",       64'(w_t),   64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
